// File: rtl/pipe_adder_128_core_pkg.sv
// Shared constants and helpers for the bit-sliced pipelined ripple-carry adder.
// The tap ports are fixed per bit, so the operand width stays at 4.
package pipe_adder_128_core_pkg;

   localparam int WIDTH   = 4;
   localparam int LATENCY = 4;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One bit slice of the pipelined adder: a full adder whose sum and carry are
// both registered, cleared asynchronously while rst_n is low.
module pipe_adder_stage
   import pipe_adder_128_core_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s  <= 1'b0;
         co <= 1'b0;
      end else begin
         s  <= a ^ b ^ ci;
         co <= maj3(a, b, ci);
      end
   end

endmodule

// File: rtl/pipe_adder_128_core.sv
// Fully pipelined 4-bit ripple-carry adder, one stage per bit. The top holds the
// operand skew chains feeding the later stages and the sum deskew chains.
module pipe_adder_128_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             A1,
   output logic             A2,
   output logic             A3,
   output logic             B1,
   output logic             B2,
   output logic             B3,
   output logic             tc0,
   output logic             tc1,
   output logic             tc2,
   output logic [WIDTH-1:0] S,
   output logic             cout
);
   import pipe_adder_128_core_pkg::*;

   logic             a2_d1;
   logic             b2_d1;
   logic [1:0]       a3_d;
   logic [1:0]       b3_d;

   logic             s0;
   logic             s1;
   logic             s2;
   logic             s3;
   logic             c3;

   // Earlier bits finish earlier, so each is held back to line up with bit 3.
   logic [LATENCY-2:0] s0_dly;
   logic [LATENCY-3:0] s1_dly;
   logic               s2_dly;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         A1     <= 1'b0;
         B1     <= 1'b0;
         a2_d1  <= 1'b0;
         b2_d1  <= 1'b0;
         A2     <= 1'b0;
         B2     <= 1'b0;
         a3_d   <= '0;
         b3_d   <= '0;
         A3     <= 1'b0;
         B3     <= 1'b0;
      end else begin
         A1     <= A[1];
         B1     <= B[1];
         a2_d1  <= A[2];
         b2_d1  <= B[2];
         A2     <= a2_d1;
         B2     <= b2_d1;
         a3_d   <= {a3_d[0], A[3]};
         b3_d   <= {b3_d[0], B[3]};
         A3     <= a3_d[1];
         B3     <= b3_d[1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_dly <= '0;
         s1_dly <= '0;
         s2_dly <= 1'b0;
      end else begin
         s0_dly <= {s0_dly[LATENCY-3:0], s0};
         s1_dly <= {s1_dly[LATENCY-4:0], s1};
         s2_dly <= s2;
      end
   end

   pipe_adder_stage u_stage0 (
      .clk   (clk),
      .rst_n (reset),
      .a     (A[0]),
      .b     (B[0]),
      .ci    (1'b0),
      .s     (s0),
      .co    (tc0)
   );

   pipe_adder_stage u_stage1 (
      .clk   (clk),
      .rst_n (reset),
      .a     (A1),
      .b     (B1),
      .ci    (tc0),
      .s     (s1),
      .co    (tc1)
   );

   pipe_adder_stage u_stage2 (
      .clk   (clk),
      .rst_n (reset),
      .a     (A2),
      .b     (B2),
      .ci    (tc1),
      .s     (s2),
      .co    (tc2)
   );

   pipe_adder_stage u_stage3 (
      .clk   (clk),
      .rst_n (reset),
      .a     (A3),
      .b     (B3),
      .ci    (tc2),
      .s     (s3),
      .co    (c3)
   );

   assign S    = {s3, s2_dly, s1_dly[LATENCY-3], s0_dly[LATENCY-2]};
   assign cout = c3;

endmodule

// File: tb/tb_pipe_adder_128_core.sv
// Scoreboard bench for pipe_adder_128_core: stimulus queues expected sums with
// the edge they are due on; a monitor compares them as the pipeline drains.
module tb_pipe_adder_128_core;
   import pipe_adder_128_core_pkg::*;

   logic       clk;
   logic       reset;
   logic [3:0] A;
   logic [3:0] B;
   logic       A1, A2, A3, B1, B2, B3;
   logic       tc0, tc1, tc2;
   logic [3:0] S;
   logic       cout;

   typedef struct {
      int         due;
      logic [4:0] val;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   edge_cnt;
   int   checks;
   int   errors;

   pipe_adder_128_core #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .A1    (A1),
      .A2    (A2),
      .A3    (A3),
      .B1    (B1),
      .B2    (B2),
      .B3    (B3),
      .tc0   (tc0),
      .tc1   (tc1),
      .tc2   (tc2),
      .S     (S),
      .cout  (cout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [13:0] all_outs();
      return {A3, A2, A1, B3, B2, B1, tc2, tc1, tc0, cout, S};
   endfunction

   // Drive one operand pair ahead of the next rising edge and queue its sum.
   task automatic apply(input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      @(negedge clk);
      A = a;
      B = b;
      e.due = edge_cnt + LATENCY;
      e.val = {1'b0, a} + {1'b0, b};
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (reset && sb_q.size() > 0) begin
         if (sb_q[0].due < edge_cnt) begin
            mon_e = sb_q.pop_front();
            chk("sb_missed", 16'(edge_cnt), 16'(mon_e.due));
         end else if (sb_q[0].due == edge_cnt) begin
            mon_e = sb_q.pop_front();
            chk("sum", {11'd0, cout, S}, {11'd0, mon_e.val});
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      A      = 4'h0;
      B      = 4'h0;
      #1 reset = 1'b0;

      // Reset holds everything at zero even with all-ones operands.
      A = 4'hF;
      B = 4'hF;
      repeat (3) begin
         @(negedge clk);
         chk("reset_zero", {2'b0, all_outs()}, 16'h0);
      end
      @(negedge clk);
      A = 4'h0;
      B = 4'h0;
      reset = 1'b1;
      repeat (6) begin
         apply(4'h0, 4'h0);
         chk("idle_zero", {2'b0, all_outs()}, 16'h0);
      end

      // Longest carry chain: watch the carry ripple through the stage registers.
      apply(4'hF, 4'hF);
      apply(4'h0, 4'h0);
      chk("chain_n_tc", {13'd0, tc2, tc1, tc0}, 16'b001);
      chk("chain_n_ab1", {14'd0, A1, B1}, 16'b11);
      apply(4'h0, 4'h0);
      chk("chain_n1_tc", {13'd0, tc2, tc1, tc0}, 16'b010);
      apply(4'h0, 4'h0);
      chk("chain_n2_tc", {13'd0, tc2, tc1, tc0}, 16'b100);
      repeat (3) apply(4'h0, 4'h0);

      // Skew taps follow each operand bit down its own delay chain.
      apply(4'b1010, 4'b0100);
      apply(4'h0, 4'h0);
      chk("skew_n_ab1", {14'd0, A1, B1}, 16'b10);
      apply(4'h0, 4'h0);
      chk("skew_n1_ab2", {14'd0, A2, B2}, 16'b01);
      chk("skew_n1_a1", {15'd0, A1}, 16'd0);
      apply(4'h0, 4'h0);
      chk("skew_n2_ab3", {14'd0, A3, B3}, 16'b10);
      repeat (3) apply(4'h0, 4'h0);

      // Back-to-back stream: 2, 16, 16, 16, 7.
      apply(4'd1, 4'd1);
      apply(4'd7, 4'd9);
      apply(4'd15, 4'd1);
      apply(4'd8, 4'd8);
      apply(4'd5, 4'd2);
      repeat (5) apply(4'h0, 4'h0);

      // Reset lands between edges n+1 and n+2 of a 15+15 wavefront.
      apply(4'hF, 4'hF);
      apply(4'h0, 4'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      sb_q.delete();
      #1 chk("midrst_now", {2'b0, all_outs()}, 16'h0);
      repeat (2) begin
         @(negedge clk);
         chk("midrst_hold", {2'b0, all_outs()}, 16'h0);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (6) begin
         apply(4'h0, 4'h0);
         chk("post_rst_sum", {11'd0, cout, S}, 16'h0);
      end

      // Random stream, one pair per cycle.
      for (int i = 0; i < 200; i++)
         apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat (LATENCY + 2) apply(4'h0, 4'h0);
      repeat (LATENCY + 1) @(negedge clk);
      chk("sb_drained", 16'(sb_q.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
